// File: rtl/a2d_scheduler.sv
// Round-robin A2D conversion scheduler: one channel (left, right, battery) per nxt
// pulse, two SPI transactions per channel because the ADC128S returns the previous conversion.
module a2d_scheduler #(
  parameter logic [2:0] LFT_CHNL    = 3'd0,
  parameter logic [2:0] RGHT_CHNL   = 3'd4,
  parameter logic [2:0] BATT_CHNL   = 3'd5,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        rnd_vld,
  output logic        busy,
  output logic        tmo_err,
  output logic [2:0]  state_dbg
);

  // SPI handshake: wrt is a one-clock start strobe issued only from CMD/READ;
  // done is a one-clock completion strobe honoured only in WAIT_CMD/WAIT_RD.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CMD      = 3'd1,
    S_WAIT_CMD = 3'd2,
    S_GAP      = 3'd3,
    S_READ     = 3'd4,
    S_WAIT_RD  = 3'd5,
    S_CAPT     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    RR_LFT  = 2'd0,
    RR_RGHT = 2'd1,
    RR_BATT = 2'd2
  } rr_t;

  localparam int              CW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYC - 1);

  state_t        state_q;
  rr_t           rr_q;
  rr_t           rr_d;
  logic [2:0]    chnl_d;
  logic [15:0]   cmd_d;
  logic [CW-1:0] tmo_cnt_q;
  logic          wrt_q;
  logic [15:0]   cmd_q;
  logic [11:0]   lft_q;
  logic [11:0]   rght_q;
  logic [11:0]   batt_q;
  logic          rnd_vld_q;
  logic          tmo_err_q;
  logic          tmo_hit;
  logic          unused_rd_hi;

  assign unused_rd_hi = &{1'b0, rd_data[15:12]};

  always_comb begin
    chnl_d = LFT_CHNL;
    rr_d   = RR_RGHT;
    case (rr_q)
      RR_LFT: begin
        chnl_d = LFT_CHNL;
        rr_d   = RR_RGHT;
      end
      RR_RGHT: begin
        chnl_d = RGHT_CHNL;
        rr_d   = RR_BATT;
      end
      RR_BATT: begin
        chnl_d = BATT_CHNL;
        rr_d   = RR_LFT;
      end
      default: begin
        chnl_d = LFT_CHNL;
        rr_d   = RR_RGHT;
      end
    endcase
  end

  assign cmd_d   = {2'b00, chnl_d, 11'h000};
  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_q      <= RR_LFT;
      tmo_cnt_q <= '0;
      wrt_q     <= 1'b0;
      cmd_q     <= 16'h0000;
      lft_q     <= 12'h000;
      rght_q    <= 12'h000;
      batt_q    <= 12'h000;
      rnd_vld_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      wrt_q     <= 1'b0;
      rnd_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (nxt) begin
            state_q <= S_CMD;
            wrt_q   <= 1'b1;
            cmd_q   <= cmd_d;
          end
        end
        S_CMD: begin
          tmo_cnt_q <= '0;
          state_q   <= S_WAIT_CMD;
        end
        // The first transaction's rd_data belongs to the previous conversion and is dropped.
        S_WAIT_CMD: begin
          if (done) begin
            state_q <= S_GAP;
          end else if (tmo_hit) begin
            tmo_err_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          state_q <= S_READ;
          wrt_q   <= 1'b1;
        end
        S_READ: begin
          tmo_cnt_q <= '0;
          state_q   <= S_WAIT_RD;
        end
        // rd_data is latched with done so the result is visible for the whole CAPT cycle.
        S_WAIT_RD: begin
          if (done) begin
            state_q   <= S_CAPT;
            rr_q      <= rr_d;
            rnd_vld_q <= (rr_q == RR_BATT);
            case (rr_q)
              RR_RGHT: rght_q <= rd_data[11:0];
              RR_BATT: batt_q <= rd_data[11:0];
              default: lft_q  <= rd_data[11:0];
            endcase
          end else if (tmo_hit) begin
            tmo_err_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        S_CAPT: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign batt      = batt_q;
  assign rnd_vld   = rnd_vld_q;
  assign busy      = (state_q != S_IDLE);
  assign tmo_err   = tmo_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_a2d_scheduler.sv
// Directed bench for a2d_scheduler: an ADC128S-style SPI model answers each wrt with the
// conversion for the previously addressed channel, so stale-data handling is observable.
module tb_a2d_scheduler;

  logic        clk;
  logic        rst_n;
  logic        nxt;
  logic        done_m;
  logic        done_s;
  logic [15:0] rd_m;
  logic [15:0] rd_s;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] batt;
  logic        rnd_vld;
  logic        busy;
  logic        tmo_err;
  logic [2:0]  state_dbg;

  assign done    = done_m | done_s;
  assign rd_data = done_s ? rd_s : rd_m;

  a2d_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nxt       (nxt),
    .wrt       (wrt),
    .cmd       (cmd),
    .done      (done),
    .rd_data   (rd_data),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .batt      (batt),
    .rnd_vld   (rnd_vld),
    .busy      (busy),
    .tmo_err   (tmo_err),
    .state_dbg (state_dbg)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        spi_en   = 1'b1;
  int          spi_lat  = 3;
  logic [11:0] lval     = 12'h130;
  logic [11:0] rval     = 12'h0F0;
  logic [11:0] bval     = 12'hC00;
  logic [2:0]  prev_ch;
  logic [11:0] mdl_d;
  int          cyc      = 0;
  int          nxt_cyc  = 0;
  int          rnd_cnt  = 0;
  int          wrt_cyc_q[$];
  int          done_cyc_q[$];
  logic [15:0] wrt_cmd_q[$];
  logic [15:0] exp_q[$];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, got no summary, want finish");
    $fatal(1);
  end

  function automatic logic [11:0] chan_val(input logic [2:0] ch);
    case (ch)
      3'd0:    return lval;
      3'd4:    return rval;
      3'd5:    return bval;
      default: return 12'hEEE;
    endcase
  endfunction

  // SPI master model with ADC128S pipelining
  initial begin
    done_m  = 1'b0;
    rd_m    = 16'h0000;
    prev_ch = 3'd7;
    forever begin
      @(posedge clk);
      if (wrt === 1'b1 && spi_en) begin
        mdl_d   = chan_val(prev_ch);
        prev_ch = cmd[13:11];
        repeat (spi_lat) @(posedge clk);
        #1 done_m = 1'b1;
        rd_m = {4'hF, mdl_d};
        @(posedge clk);
        #1 done_m = 1'b0;
        rd_m = 16'h0000;
      end
    end
  end

  // monitor
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (nxt === 1'b1) nxt_cyc = cyc;
    if (wrt === 1'b1) begin
      wrt_cmd_q.push_back(cmd);
      wrt_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) done_cyc_q.push_back(cyc);
    if (rnd_vld === 1'b1) rnd_cnt = rnd_cnt + 1;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_nxt();
    nxt = 1'b1;
    tick();
    nxt = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < budget) begin
      tick();
      i++;
    end
    if (busy !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", tag, busy, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    nxt   = 1'b0;
    repeat (2) tick();
    n_checks++; if (wrt !== 1'b0) begin n_fail++; $display("FAIL reset_wrt: got %b want 0", wrt); end
    n_checks++; if (cmd !== 16'h0000) begin n_fail++; $display("FAIL reset_cmd: got %h want 0000", cmd); end
    n_checks++; if ({lft_ld, rght_ld, batt} !== 36'h0) begin n_fail++; $display("FAIL reset_results: got %h %h %h want 000", lft_ld, rght_ld, batt); end
    n_checks++; if (rnd_vld !== 1'b0) begin n_fail++; $display("FAIL reset_rnd_vld: got %b want 0", rnd_vld); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL reset_tmo_err: got %b want 0", tmo_err); end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_round();
    lval = 12'h130; rval = 12'h0F0; bval = 12'hC00;
    wrt_cmd_q.delete();
    rnd_cnt = 0;
    exp_q = '{16'h0000, 16'h0000, 16'h2000, 16'h2000, 16'h2800, 16'h2800};
    for (int k = 0; k < 3; k++) begin
      pulse_nxt();
      wait_idle(200, "round");
      n_checks++;
      if (rnd_cnt != ((k == 2) ? 1 : 0)) begin
        n_fail++; $display("FAIL round_rnd_vld_%0d: got %0d pulses want %0d", k, rnd_cnt, (k == 2) ? 1 : 0);
      end
    end
    n_checks++;
    if (wrt_cmd_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL round_wrt_count: got %0d want %0d", wrt_cmd_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wrt_cmd_q.size(); i++) begin
      n_checks++;
      if (wrt_cmd_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL round_cmd_%0d: got %h want %h", i, wrt_cmd_q[i], exp_q[i]); end
    end
    n_checks++; if (lft_ld !== 12'h130) begin n_fail++; $display("FAIL round_lft: got %h want 130", lft_ld); end
    n_checks++; if (rght_ld !== 12'h0F0) begin n_fail++; $display("FAIL round_rght: got %h want 0F0", rght_ld); end
    n_checks++; if (batt !== 12'hC00) begin n_fail++; $display("FAIL round_batt: got %h want C00", batt); end
  endtask

  task automatic test_latency();
    wrt_cyc_q.delete();
    done_cyc_q.delete();
    pulse_nxt();
    n_checks++; if (wrt !== 1'b1) begin n_fail++; $display("FAIL lat_wrt_first: got %b want 1", wrt); end
    tick();
    n_checks++; if (wrt !== 1'b0) begin n_fail++; $display("FAIL lat_wrt_width: got %b want 0", wrt); end
    wait_idle(200, "lat");
    n_checks++;
    if (wrt_cyc_q.size() != 2 || done_cyc_q.size() != 2) begin
      n_fail++; $display("FAIL lat_counts: got wrt=%0d done=%0d want 2 2", wrt_cyc_q.size(), done_cyc_q.size());
    end else begin
      n_checks++;
      if (wrt_cyc_q[0] - nxt_cyc != 1) begin n_fail++; $display("FAIL lat_nxt_to_wrt: got %0d want 1", wrt_cyc_q[0] - nxt_cyc); end
      n_checks++;
      if (wrt_cyc_q[1] - done_cyc_q[0] != 2) begin n_fail++; $display("FAIL lat_done_to_wrt: got %0d want 2", wrt_cyc_q[1] - done_cyc_q[0]); end
    end
    n_checks++; if (lft_ld !== 12'h130) begin n_fail++; $display("FAIL lat_lft: got %h want 130", lft_ld); end
  endtask

  task automatic test_busy_drop();
    rval = 12'h5A5;
    bval = 12'h777;
    wrt_cmd_q.delete();
    pulse_nxt();
    repeat (5) begin
      nxt = 1'b1; tick();
      nxt = 1'b0; tick();
    end
    wait_idle(200, "drop");
    repeat (10) tick();
    n_checks++;
    if (wrt_cmd_q.size() != 2) begin
      n_fail++; $display("FAIL drop_wrt_count: got %0d want 2", wrt_cmd_q.size());
    end else begin
      n_checks++;
      if (wrt_cmd_q[0] !== 16'h2000 || wrt_cmd_q[1] !== 16'h2000) begin
        n_fail++; $display("FAIL drop_cmd: got %h %h want 2000 2000", wrt_cmd_q[0], wrt_cmd_q[1]);
      end
    end
    n_checks++; if (rght_ld !== 12'h5A5) begin n_fail++; $display("FAIL drop_rght: got %h want 5A5", rght_ld); end
    wrt_cmd_q.delete();
    pulse_nxt();
    wait_idle(200, "drop_next");
    n_checks++;
    if (wrt_cmd_q.size() != 2 || wrt_cmd_q[0] !== 16'h2800) begin
      n_fail++; $display("FAIL drop_rr_next: got %0d wrts first %h want 2 2800", wrt_cmd_q.size(), (wrt_cmd_q.size() > 0) ? wrt_cmd_q[0] : 16'hxxxx);
    end
    n_checks++; if (batt !== 12'h777) begin n_fail++; $display("FAIL drop_batt: got %h want 777", batt); end
  endtask

  task automatic test_timeout();
    int i;
    pulse_nxt();
    wait_idle(200, "tmo_lft");
    wrt_cmd_q.delete();
    wrt_cyc_q.delete();
    pulse_nxt();
    i = 0;
    while (done !== 1'b1 && i < 100) begin tick(); i++; end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL tmo_first_done: got %b want 1", done); end
    spi_en = 1'b0;
    wait_idle(5000, "tmo");
    n_checks++; if (tmo_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err_set: got %b want 1", tmo_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b want 0", busy); end
    n_checks++; if (rght_ld !== 12'h5A5) begin n_fail++; $display("FAIL tmo_rght_kept: got %h want 5A5", rght_ld); end
    n_checks++;
    if (wrt_cyc_q.size() != 2) begin
      n_fail++; $display("FAIL tmo_wrt_count: got %0d want 2", wrt_cyc_q.size());
    end else begin
      n_checks++;
      if (cyc - wrt_cyc_q[1] != 4096) begin n_fail++; $display("FAIL tmo_duration: got %0d want 4096", cyc - wrt_cyc_q[1]); end
    end
    spi_en = 1'b1;
    rval = 12'h3C3;
    wrt_cmd_q.delete();
    pulse_nxt();
    wait_idle(200, "tmo_retry");
    n_checks++;
    if (wrt_cmd_q.size() != 2 || wrt_cmd_q[0] !== 16'h2000) begin
      n_fail++; $display("FAIL tmo_retry_cmd: got %0d wrts first %h want 2 2000", wrt_cmd_q.size(), (wrt_cmd_q.size() > 0) ? wrt_cmd_q[0] : 16'hxxxx);
    end
    n_checks++; if (rght_ld !== 12'h3C3) begin n_fail++; $display("FAIL tmo_retry_rght: got %h want 3C3", rght_ld); end
    n_checks++; if (tmo_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err_sticky: got %b want 1", tmo_err); end
  endtask

  task automatic test_reset_mid();
    int i;
    wrt_cmd_q.delete();
    pulse_nxt();
    i = 0;
    while (wrt_cmd_q.size() < 2 && i < 100) begin tick(); i++; end
    n_checks++;
    if (state_dbg !== 3'd5 || busy !== 1'b1) begin n_fail++; $display("FAIL rmid_in_wait_rd: got state=%0d busy=%b want 5 1", state_dbg, busy); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_checks++; if (wrt !== 1'b0) begin n_fail++; $display("FAIL rmid_wrt: got %b want 0", wrt); end
    n_checks++; if ({lft_ld, rght_ld, batt} !== 36'h0) begin n_fail++; $display("FAIL rmid_results: got %h %h %h want 000", lft_ld, rght_ld, batt); end
    n_checks++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL rmid_tmo_err: got %b want 0", tmo_err); end
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    wrt_cmd_q.delete();
    pulse_nxt();
    wait_idle(200, "rmid_next");
    n_checks++;
    if (wrt_cmd_q.size() != 2 || wrt_cmd_q[0] !== 16'h0000) begin
      n_fail++; $display("FAIL rmid_next_cmd: got %0d wrts first %h want 2 0000", wrt_cmd_q.size(), (wrt_cmd_q.size() > 0) ? wrt_cmd_q[0] : 16'hxxxx);
    end
    n_checks++; if (lft_ld !== 12'h130) begin n_fail++; $display("FAIL rmid_next_lft: got %h want 130", lft_ld); end
    // second case: reset while the first wrt is still high
    wrt_cmd_q.delete();
    pulse_nxt();
    n_checks++; if (wrt !== 1'b1) begin n_fail++; $display("FAIL rcmd_wrt_pre: got %b want 1", wrt); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (wrt !== 1'b0) begin n_fail++; $display("FAIL rcmd_wrt_async: got %b want 0", wrt); end
    n_checks++; if (cmd !== 16'h0000) begin n_fail++; $display("FAIL rcmd_cmd: got %h want 0000", cmd); end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_checks++; if (wrt_cmd_q.size() != 0) begin n_fail++; $display("FAIL rcmd_no_wrt: got %0d want 0", wrt_cmd_q.size()); end
    pulse_nxt();
    wait_idle(200, "rcmd_next");
    n_checks++;
    if (wrt_cmd_q.size() != 2 || wrt_cmd_q[0] !== 16'h0000) begin
      n_fail++; $display("FAIL rcmd_next_cmd: got %0d wrts first %h want 2 0000", wrt_cmd_q.size(), (wrt_cmd_q.size() > 0) ? wrt_cmd_q[0] : 16'hxxxx);
    end
  endtask

  task automatic test_stray_done();
    int rnd0;
    rnd0 = rnd_cnt;
    wrt_cmd_q.delete();
    done_s = 1'b1;
    rd_s   = 16'h0ABC;
    tick();
    done_s = 1'b0;
    rd_s   = 16'h0000;
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stray_busy: got %b want 0", busy); end
    n_checks++; if (rnd_cnt != rnd0) begin n_fail++; $display("FAIL stray_rnd_vld: got %0d pulses want %0d", rnd_cnt, rnd0); end
    n_checks++; if ({lft_ld, rght_ld, batt} !== {12'h130, 12'h000, 12'h000}) begin n_fail++; $display("FAIL stray_results: got %h %h %h want 130 000 000", lft_ld, rght_ld, batt); end
    n_checks++; if (wrt_cmd_q.size() != 0) begin n_fail++; $display("FAIL stray_wrt: got %0d want 0", wrt_cmd_q.size()); end
    rval = 12'h246;
    pulse_nxt();
    wait_idle(200, "stray_next");
    n_checks++;
    if (wrt_cmd_q.size() != 2 || wrt_cmd_q[0] !== 16'h2000) begin
      n_fail++; $display("FAIL stray_next_cmd: got %0d wrts first %h want 2 2000", wrt_cmd_q.size(), (wrt_cmd_q.size() > 0) ? wrt_cmd_q[0] : 16'hxxxx);
    end
    n_checks++; if (rght_ld !== 12'h246) begin n_fail++; $display("FAIL stray_next_rght: got %h want 246", rght_ld); end
  endtask

  initial begin
    rst_n  = 1'b0;
    nxt    = 1'b0;
    done_s = 1'b0;
    rd_s   = 16'h0000;
    test_reset();
    test_round();
    test_latency();
    test_busy_drop();
    test_timeout();
    test_reset_mid();
    test_stray_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/a2d_scheduler.md
Name: a2d_scheduler

Overview:
- Sequences the ADC128S-side SPI master to convert the left load cell, right load cell and battery channels in round-robin order, one channel per trigger pulse.
- Holds the latest 12-bit result per channel for the steering-enable and battery-monitor logic.
- Sits between the inertial-side timing pulse (nxt) and the shared A2D SPI master. It is the only requester allowed to drive that master.

Parameters:
- LFT_CHNL, 3'd0, ADC channel for the left load cell.
- RGHT_CHNL, 3'd4, ADC channel for the right load cell.
- BATT_CHNL, 3'd5, ADC channel for the battery.
- TIMEOUT_CYC, 4096, maximum clocks to wait for done after any wrt before aborting.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- nxt  in  1  single-cycle trigger; starts one conversion
- wrt  out  1  single-cycle start strobe to the SPI master
- cmd  out  16  SPI word: {2'b00, chnl[2:0], 11'h000}
- done  in  1  single-cycle completion strobe from the SPI master
- rd_data  in  16  SPI master receive word; result is in bits [11:0]
- lft_ld  out  12  latest left load-cell result
- rght_ld  out  12  latest right load-cell result
- batt  out  12  latest battery result
- rnd_vld  out  1  one-cycle pulse when the battery result (end of round) is captured
- busy  out  1  high whenever the FSM is not in IDLE
- tmo_err  out  1  sticky timeout flag

Behaviour:

Clock and reset:
- One clock domain.
- rst_n is asynchronous and active-low.

Reset state:
- wrt=0, cmd=16'h0000.
- lft_ld, rght_ld, batt = 12'h000.
- rnd_vld=0, busy=0, tmo_err=0.
- Round-robin pointer rr=LFT. FSM in IDLE. Timeout counter = 0.

Round-robin order:
- LFT -> RGHT -> BATT -> LFT.
- rr advances only after a successful capture.

FSM states and transitions:
- IDLE: when nxt is sampled high, go to CMD. nxt while busy is dropped, not queued. done seen in IDLE is ignored.
- CMD: assert wrt for exactly one clock. cmd holds the channel word for rr. Clear the timeout counter. Go to WAIT_CMD.
- WAIT_CMD: on done, go to GAP. The returned data is stale (ADC128S pipelining) and is discarded.
- GAP: one idle clock. Go to READ.
- READ: assert wrt for one clock with the same cmd. Clear the timeout counter. Go to WAIT_RD.
- WAIT_RD: on done, go to CAPT.
- CAPT: load rd_data[11:0] into the register selected by rr. Advance rr. If rr was BATT, pulse rnd_vld for this one clock. Go to IDLE.

Latency:
- nxt sampled at edge N: first wrt is high during cycle N+1.
- Minimum nxt-to-result latency: 2 SPI transactions + 4 clocks.

Outputs:
- cmd is registered and updates on entry to CMD.
- cmd holds its value until the next CMD state.
- Result registers change only in CMD-independent CAPT, i.e. only in CAPT.

Timeout:
- In WAIT_CMD or WAIT_RD, the counter increments each clock.
- If the counter reaches TIMEOUT_CYC-1 without done: set tmo_err, go to IDLE.
- On timeout, rr is unchanged and the result registers are unchanged. The next nxt retries the same channel.
- tmo_err stays set until reset. Successful conversions continue normally.
- done arriving in the same cycle the counter hits the limit counts as success.

Handshake rules:
- Never assert wrt while waiting for done.
- At most one outstanding transaction.

Reset mid-operation:
- Everything returns to reset values immediately.
- wrt is deasserted asynchronously.

Test Plan:
- Reset then 3 nxt pulses. SPI model returns 12'h130, 12'h0F0, 12'hC00. Required: cmd words 16'h0000, 16'h2000, 16'h2800, each sent twice. lft_ld=12'h130, rght_ld=12'h0F0, batt=12'hC00. rnd_vld pulses once, on the 3rd capture only.
- nxt at edge N -> wrt high exactly in cycle N+1 and one clock wide. The second wrt comes exactly 2 clocks after the first done.
- nxt pulsed 5 times while busy -> no extra wrt. Exactly one conversion completes. rr advances by 1.
- Withhold done after the second wrt for 4096 clocks -> tmo_err=1, busy=0, rght_ld unchanged. The next nxt re-issues cmd 16'h2000 (same channel).
- Assert rst_n low while in WAIT_RD -> busy, wrt, all results and tmo_err read 0 before the next edge. The next nxt converts the LFT channel.
- Stray done pulse in IDLE -> no state change, no register update, no rnd_vld.
